lmsm_sequencer: RTL and testbench
=================================

// Module: lmsm_sequencer
// PURPOSE
//  Sequences the load-multiple (LM) and store-multiple (SM) instructions of the multicycle core.
//  Walks an 8-bit register mask from R0 to R7, one memory word per selected register.
//  Drives the RF read/write addresses and the memory request, address and write-enable to the datapath.
//  The main controller hands off with start and resumes on done.
// PARAMETERS
//  NREG  8   number of architectural registers (mask width)
//  IW    3   register index width, log2(NREG)
//  AW    16  memory address width
//  CW    4   transfer count width, log2(NREG)+1
// PORTS
//  clk          in   1     core clock; all state changes on its rising edge
//  reset_n      in   1     asynchronous, active-low reset
//  start        in   1     begin an LM/SM; sampled only in IDLE
//  is_store     in   1     1 = SM (RF->mem), 0 = LM (mem->RF); sampled with start
//  reg_mask     in   NREG  bit i set = transfer Ri; sampled with start
//  base_addr    in   AW    address of first word; sampled with start
//  mem_ack      in   1     memory completed the current access this cycle
//  mem_req      out  1     memory access request
//  mem_we       out  1     1 = write (SM); valid only while mem_req=1
//  mem_addr     out  AW    memory address of the current access
//  rf_radd      out  IW    RF read port-2 address (SM store data source)
//  rf_wen       out  1     RF write enable (LM; data comes from the memory read data)
//  rf_wadd      out  IW    RF write address
//  busy         out  1     sequence in progress (ACCESS or DONE)
//  done         out  1     one-cycle completion pulse
//  xfer_count   out  CW    words transferred; updated at done, held until the next start
// BEHAVIOUR
//  Reset: state=IDLE. mem_req, mem_we, rf_wen, busy and done are 0. mem_addr, rf_radd,
//   rf_wadd, xfer_count, remaining mask and direction registers are 0.
//  IDLE:
//   - start=1 latches reg_mask->rem, base_addr->addr_q and is_store->dir; count_q is cleared.
//   - Next state is ACCESS if reg_mask!=0, else DONE.
//   - start in any other state is ignored.
//  ACCESS:
//   - idx is the lowest set bit of rem (ascending priority R0 first).
//   - mem_req=1, mem_addr=addr_q, mem_we=dir.
//   - rf_radd=idx when SM, 0 otherwise; rf_wadd=idx.
//   - mem_ack=0: hold every output stable and do not write the RF.
//   - mem_ack=1 with LM: rf_wen=1 in that same cycle (combinational on mem_ack).
//   - mem_ack=1 (either direction): clear rem[idx], addr_q<=addr_q+1 modulo 2^AW, count_q++.
//   - Go to DONE when the cleared rem becomes 0, else stay in ACCESS.
//  DONE: done=1 and busy=1 for one cycle; xfer_count<=count_q; next state IDLE.
//   - A start arriving in this cycle is ignored; the controller re-issues start in IDLE.
//  busy=0 in IDLE; busy=1 in ACCESS and DONE.
//  Latency with zero-wait memory (start accepted in cycle 0, N = popcount(mask)):
//   - ACCESS occupies cycles 1..N; done pulses in cycle N+1; N=0 gives done in cycle 1.
//  Each extra mem_ack=0 cycle adds one cycle. A transfer is never skipped or repeated.
//  mem_ack while mem_req=0 is ignored.
//  Address wrap: 0xFFFF+1 gives 0x0000 with no error indication.
//  reset_n asserted mid-sequence:
//   - All outputs return to reset values immediately; no further RF or memory writes occur.
//   - Writes already acknowledged are not undone.
//   - A new start after deassertion runs normally.
//  No output is registered through the memory; rf_wen/mem_we depend only on state, dir and mem_ack.
// TESTING
//  1 LM, mask=8'b1000_0101, base=0x0040, mem_ack=1 every cycle:
//    RF writes R0<-[0x0040], R2<-[0x0041], R7<-[0x0042] in cycles 1-3; done in cycle 4; xfer_count=3.
//  2 SM, mask=8'hFF, base=0xFFFE, ack every cycle:
//    mem_addr FFFE,FFFF,0000..0005 with rf_radd 0..7; mem_we=1 throughout; rf_wen never 1; done in cycle 9.
//  3 mask=0, either direction:
//    mem_req never 1; done in cycle 1; xfer_count=0; busy high in cycle 1 only.
//  4 LM, mask=8'h0A, mem_ack low 2 cycles before each ack:
//    mem_addr/rf_wadd stable during the stall; rf_wen=1 only on ack cycles (R1 then R3); done in cycle 7.
//  5 start pulsed during ACCESS with a different mask:
//    the ongoing sequence is unaffected; xfer_count equals the original popcount.
//  6 reset_n low in cycle 2 of an 8-word SM:
//    mem_req/busy 0 at once, no further writes; a fresh LM with mask=8'h01 completes with done in cycle 2.

Source files
------------

// File: rtl/lmsm_sequencer_if.sv
// Bundle between the LM/SM sequencer, the main controller, the register file and memory.
// master = controller/memory side, slave = sequencer side.
interface lmsm_sequencer_if #(
    parameter int NREG = 8,
    parameter int IW   = 3,
    parameter int AW   = 16,
    parameter int CW   = 4
);
    logic            start;
    logic            is_store;
    logic [NREG-1:0] reg_mask;
    logic [AW-1:0]   base_addr;
    logic            mem_ack;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [IW-1:0]   rf_radd;
    logic            rf_wen;
    logic [IW-1:0]   rf_wadd;
    logic            busy;
    logic            done;
    logic [CW-1:0]   xfer_count;

    modport master (
        output start, is_store, reg_mask, base_addr, mem_ack,
        input  mem_req, mem_we, mem_addr, rf_radd, rf_wen, rf_wadd, busy, done, xfer_count
    );

    modport slave (
        input  start, is_store, reg_mask, base_addr, mem_ack,
        output mem_req, mem_we, mem_addr, rf_radd, rf_wen, rf_wadd, busy, done, xfer_count
    );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks a register mask R0..R7, issuing one memory
// access per selected register, then pulses done for the main controller.
module lmsm_sequencer #(
    parameter int NREG = 8,
    parameter int IW   = 3,
    parameter int AW   = 16,
    parameter int CW   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    lmsm_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [NREG-1:0] rem_q, rem_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            dir_q, dir_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   xfer_q, xfer_d;

    logic [IW-1:0]   idx;
    logic [NREG-1:0] rem_clr;

    // Lowest set bit wins, so R0 is transferred first.
    always_comb begin
        idx = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if (rem_q[i]) idx = IW'(i);
        end
    end

    assign rem_clr = rem_q & (rem_q - NREG'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rem_q   <= '0;
            addr_q  <= '0;
            dir_q   <= 1'b0;
            count_q <= '0;
            xfer_q  <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            xfer_q  <= xfer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        addr_d      = addr_q;
        dir_d       = dir_q;
        count_d     = count_q;
        xfer_d      = xfer_q;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        bus.rf_wen  = 1'b0;
        bus.rf_radd = '0;
        bus.rf_wadd = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    rem_d   = bus.reg_mask;
                    addr_d  = bus.base_addr;
                    dir_d   = bus.is_store;
                    count_d = '0;
                    state_d = (bus.reg_mask != '0) ? ACCESS : DONE;
                end
            end
            ACCESS: begin
                bus.busy    = 1'b1;
                bus.mem_req = 1'b1;
                bus.mem_we  = dir_q;
                bus.rf_radd = dir_q ? idx : '0;
                bus.rf_wadd = idx;
                // Everything holds while memory stalls; advance only on ack.
                if (bus.mem_ack) begin
                    bus.rf_wen = ~dir_q;
                    rem_d      = rem_clr;
                    addr_d     = addr_q + AW'(1);
                    count_d    = count_q + CW'(1);
                    if (rem_clr == '0) state_d = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                xfer_d   = count_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_addr   = addr_q;
    assign bus.xfer_count = xfer_q;
endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer: cycle-accurate checks of the LM/SM walk,
// stalls, address wrap, ignored starts and mid-sequence reset.
module tb_lmsm_sequencer;
    localparam int NREG = 8;
    localparam int IW   = 3;
    localparam int AW   = 16;
    localparam int CW   = 4;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;

    lmsm_sequencer_if #(.NREG(NREG), .IW(IW), .AW(AW), .CW(CW)) bus ();

    lmsm_sequencer #(.NREG(NREG), .IW(IW), .AW(AW), .CW(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Start is presented in cycle 0; on return the bench is in cycle 1.
    task automatic issue_start(input logic store, input logic [7:0] mask, input logic [15:0] base);
        bus.start     = 1'b1;
        bus.is_store  = store;
        bus.reg_mask  = mask;
        bus.base_addr = base;
        next_cycle();
        bus.start     = 1'b0;
        bus.reg_mask  = 8'h00;
        bus.base_addr = 16'h0000;
        bus.is_store  = 1'b0;
    endtask

    // Checks one ACCESS cycle at the falling edge.
    task automatic check_access(input string tag, input logic store, input logic [2:0] ridx,
                                input logic [15:0] addr, input logic ack);
        @(negedge clk);
        check({tag, ".mem_req"}, bus.mem_req, 1'b1);
        check({tag, ".mem_we"},  bus.mem_we, store);
        check({tag, ".addr"},    bus.mem_addr, addr);
        check({tag, ".wadd"},    bus.rf_wadd, ridx);
        check({tag, ".radd"},    bus.rf_radd, store ? ridx : 3'd0);
        check({tag, ".rf_wen"},  bus.rf_wen, (!store) && ack);
        check({tag, ".busy"},    bus.busy, 1'b1);
        check({tag, ".done"},    bus.done, 1'b0);
        next_cycle();
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check({tag, ".done"},    bus.done, 1'b1);
        check({tag, ".busy"},    bus.busy, 1'b1);
        check({tag, ".mem_req"}, bus.mem_req, 1'b0);
        check({tag, ".rf_wen"},  bus.rf_wen, 1'b0);
        next_cycle();
    endtask

    task automatic check_idle(input string tag, input logic [3:0] cnt);
        @(negedge clk);
        check({tag, ".done"},  bus.done, 1'b0);
        check({tag, ".busy"},  bus.busy, 1'b0);
        check({tag, ".xfer"},  bus.xfer_count, cnt);
    endtask

    logic [2:0]  t1_idx [3] = '{3'd0, 3'd2, 3'd7};
    logic        t4_ack [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  t4_idx [6] = '{3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3};
    logic [15:0] a;

    initial begin
        bus.start     = 1'b0;
        bus.is_store  = 1'b0;
        bus.reg_mask  = 8'h00;
        bus.base_addr = 16'h0000;
        bus.mem_ack   = 1'b1;

        // Reset state
        #2;
        check("rst.mem_req", bus.mem_req, 1'b0);
        check("rst.mem_we",  bus.mem_we, 1'b0);
        check("rst.rf_wen",  bus.rf_wen, 1'b0);
        check("rst.busy",    bus.busy, 1'b0);
        check("rst.done",    bus.done, 1'b0);
        check("rst.addr",    bus.mem_addr, 16'h0000);
        check("rst.xfer",    bus.xfer_count, 4'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        // mem_ack is high while idle and must be ignored
        check_idle("idle_ack", 4'd0);
        next_cycle();

        // Test 1: LM mask 0x85 base 0x0040, ack every cycle
        issue_start(1'b0, 8'h85, 16'h0040);
        for (int i = 0; i < 3; i++)
            check_access($sformatf("t1.c%0d", i + 1), 1'b0, t1_idx[i], 16'h0040 + 16'(i), 1'b1);
        check_done("t1.c4");
        check_idle("t1.c5", 4'd3);
        $display("[TB] test1 LM mask=85 base=0040 finished");
        next_cycle();

        // Test 2: SM mask 0xFF base 0xFFFE, address wraps
        issue_start(1'b1, 8'hFF, 16'hFFFE);
        for (int i = 0; i < 8; i++) begin
            a = 16'hFFFE + 16'(i);
            check_access($sformatf("t2.c%0d", i + 1), 1'b1, 3'(i), a, 1'b1);
        end
        check_done("t2.c9");
        check_idle("t2.c10", 4'd8);
        $display("[TB] test2 SM mask=FF base=FFFE finished");
        next_cycle();

        // Test 3: empty mask goes straight to DONE
        issue_start(1'b1, 8'h00, 16'h1234);
        check_done("t3.c1");
        check_idle("t3.c2", 4'd0);
        $display("[TB] test3 empty mask finished");
        next_cycle();

        // Test 4: LM mask 0x0A with two stall cycles before each ack
        issue_start(1'b0, 8'h0A, 16'h1000);
        for (int i = 0; i < 6; i++) begin
            bus.mem_ack = t4_ack[i];
            check_access($sformatf("t4.c%0d", i + 1), 1'b0, t4_idx[i],
                         (i < 3) ? 16'h1000 : 16'h1001, t4_ack[i]);
        end
        bus.mem_ack = 1'b1;
        check_done("t4.c7");
        check_idle("t4.c8", 4'd2);
        $display("[TB] test4 LM with stalls finished");
        next_cycle();

        // Test 5: start during ACCESS and during DONE is ignored
        issue_start(1'b0, 8'h03, 16'h0300);
        bus.start    = 1'b1;
        bus.is_store = 1'b1;
        bus.reg_mask = 8'hF0;
        check_access("t5.c1", 1'b0, 3'd0, 16'h0300, 1'b1);
        check_access("t5.c2", 1'b0, 3'd1, 16'h0301, 1'b1);
        check_done("t5.c3");
        bus.start    = 1'b0;
        bus.is_store = 1'b0;
        bus.reg_mask = 8'h00;
        check_idle("t5.c4", 4'd2);
        $display("[TB] test5 ignored start finished");
        next_cycle();

        // Test 6: reset mid-SM, then a fresh single-word LM
        issue_start(1'b1, 8'hFF, 16'h0200);
        check_access("t6.c1", 1'b1, 3'd0, 16'h0200, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t6.rst.mem_req", bus.mem_req, 1'b0);
        check("t6.rst.busy",    bus.busy, 1'b0);
        check("t6.rst.mem_we",  bus.mem_we, 1'b0);
        check("t6.rst.addr",    bus.mem_addr, 16'h0000);
        check("t6.rst.xfer",    bus.xfer_count, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6.hold%0d.mem_req", i), bus.mem_req, 1'b0);
            check($sformatf("t6.hold%0d.rf_wen", i),  bus.rf_wen, 1'b0);
        end
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
        issue_start(1'b0, 8'h01, 16'h0050);
        check_access("t6.lm.c1", 1'b0, 3'd0, 16'h0050, 1'b1);
        check_done("t6.lm.c2");
        check_idle("t6.lm.c3", 4'd1);
        $display("[TB] test6 reset mid-sequence finished");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
